// File: rtl/prog_load_ctrl.sv
// Boot-time program loader: packs UART RX bytes into 32-bit LE words,
// writes them to instruction memory and holds the core in reset until done.
module prog_load_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] TERM_WORD = 32'h0000_0FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_valid_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_no,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_asm;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [7:0]        r_skid;
  logic              r_skid_vld;

  logic              w_byte_vld;
  logic [7:0]        w_byte;
  logic [31:0]       w_word;
  logic              w_last;
  logic              w_term;
  logic              w_full;
  logic              w_fire;
  logic              w_ovf;

  // A held skid byte always goes ahead of a fresh arrival.
  assign w_byte     = r_skid_vld ? r_skid : rx_byte_i;
  assign w_byte_vld = (r_state == S_RECV) &&
                      (r_skid_vld || rx_valid_i);
  assign w_word     = {w_byte, r_asm};
  assign w_last     = w_byte_vld && (r_bcnt == 2'd3);
  assign w_term     = (w_word == TERM_WORD);
  assign w_full     = (r_cnt == CAP);
  assign w_fire     = (r_state == S_WRITE) && mem_gnt_i;
  assign w_ovf      = (r_state == S_WRITE) &&
                      rx_valid_i && r_skid_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en_i) w_state_nxt = S_RECV;
      end
      S_RECV: begin
        if (w_last) begin
          unique case (1'b1)
            w_term:            w_state_nxt = S_DONE;
            !w_term && w_full: w_state_nxt = S_ERROR;
            default:           w_state_nxt = S_WRITE;
          endcase
        end
      end
      S_WRITE: begin
        if (w_ovf) begin
          w_state_nxt = S_ERROR;
        end else if (mem_gnt_i) begin
          w_state_nxt = S_RECV;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bcnt     <= '0;
      r_asm      <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
    end else begin
      if (w_byte_vld) begin
        r_bcnt <= r_bcnt + 2'd1;
        unique case (r_bcnt)
          2'd0:    r_asm[7:0]   <= w_byte;
          2'd1:    r_asm[15:8]  <= w_byte;
          2'd2:    r_asm[23:16] <= w_byte;
          default: ;
        endcase
      end
      if (w_last && !w_term && !w_full) begin
        r_wdata <= w_word;
      end
      if (w_fire) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt + (ADDR_W+1)'(1);
      end
      unique case (r_state)
        S_RECV: begin
          if (r_skid_vld) begin
            r_skid_vld <= rx_valid_i;
            r_skid     <= rx_byte_i;
          end
        end
        S_WRITE: begin
          if (rx_valid_i && !r_skid_vld) begin
            r_skid_vld <= 1'b1;
            r_skid     <= rx_byte_i;
          end
        end
        default: r_skid_vld <= 1'b0;
      endcase
    end
  end

  assign mem_req_o   = (r_state == S_WRITE);
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign core_rst_no = (r_state == S_DONE);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = (r_state == S_ERROR);
  assign word_cnt_o  = r_cnt;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: scoreboard of expected memory writes,
// one task per scenario.
module tb_prog_load_ctrl;

  localparam int AW = 2;
  localparam logic [31:0] TERM = 32'h0000_0FFF;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          req;
  logic          gnt;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          core_rst_n;
  logic          done;
  logic          err;
  logic [AW:0]   cnt;

  logic [AW+31:0] sb[$];
  logic [AW-1:0]  m_addr;
  logic [AW:0]    m_cnt;
  int             n_req;
  int             n_checks;
  int             n_pass;

  prog_load_ctrl #(.ADDR_W(AW), .TERM_WORD(TERM)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .mem_req_o  (req),
    .mem_gnt_i  (gnt),
    .mem_addr_o (addr),
    .mem_wdata_o(wdata),
    .core_rst_no(core_rst_n),
    .done_o     (done),
    .err_o      (err),
    .word_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [AW+31:0] exp_w;
    if (rst_n && req && gnt) begin
      n_req++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL write_unexpected got addr=%0h data=%h want none",
                 addr, wdata);
      end else begin
        exp_w = sb.pop_front();
        if ({addr, wdata} !== exp_w)
          $display("FAIL write got addr=%0h data=%h want addr=%0h data=%h",
                   addr, wdata, exp_w[AW+31:32], exp_w[31:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit wr);
    if (wr) begin
      sb.push_back({m_addr, w});
      m_addr++;
      m_cnt++;
    end
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    idle(3);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    sb.delete();
    m_addr   = '0;
    m_cnt    = '0;
    idle(2);
    n_req    = 0;
    rst_n    = 1'b1;
    idle(2);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == TERM) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; gnt = 1'b0;
    rx_valid = 1'b0; rx_byte = '0;
    #1;
    n_checks++;
    if ({req, done, err, core_rst_n, cnt, addr, wdata} !== '0)
      $display("FAIL reset_out got req=%b done=%b err=%b crst=%b cnt=%0d want all 0",
               req, done, err, core_rst_n, cnt);
    else n_pass++;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h5A);
    idle(2);
    n_checks++;
    if ({req, done, err, core_rst_n, cnt} !== '0 || n_req !== 0)
      $display("FAIL idle_disabled got req=%b done=%b cnt=%0d nreq=%0d want 0",
               req, done, cnt, n_req);
    else n_pass++;
  endtask

  task automatic test_basic();
    en = 1'b1; gnt = 1'b1;
    do_reset();
    send_word(32'h1234_5678, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    wait_drain();
    send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h00);
    n_checks++;
    if (done !== 1'b0 || core_rst_n !== 1'b0)
      $display("FAIL basic_pre_done got done=%b crst=%b want 0 0", done, core_rst_n);
    else n_pass++;
    send_byte(8'h00);
    n_checks++;
    if (done !== 1'b1 || core_rst_n !== 1'b1 || err !== 1'b0)
      $display("FAIL basic_done got done=%b crst=%b err=%b want 1 1 0",
               done, core_rst_n, err);
    else n_pass++;
    for (int i = 0; i < 8; i++) send_byte(8'h3C);
    idle(2);
    n_checks++;
    if (cnt !== m_cnt || n_req !== 2 || done !== 1'b1 || sb.size() != 0)
      $display("FAIL basic_count got cnt=%0d nreq=%0d done=%b want cnt=%0d nreq=2 done=1",
               cnt, n_req, done, m_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    en = 1'b1; gnt = 1'b0;
    do_reset();
    sb.push_back({m_addr, 32'hCAFE_F00D});
    m_addr++; m_cnt++;
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE);
    n_checks++;
    if (req !== 1'b0)
      $display("FAIL bp_req_early got req=%b want 0", req);
    else n_pass++;
    send_byte(8'hCA);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (req !== 1'b1 || addr !== 2'd0 || wdata !== 32'hCAFE_F00D)
        $display("FAIL bp_stall%0d got req=%b addr=%0h data=%h want 1 0 cafef00d",
                 k, req, addr, wdata);
      else n_pass++;
      if (k == 1) begin
        rx_byte = 8'h44; rx_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
    gnt = 1'b1;
    idle(2);
    sb.push_back({m_addr, 32'h1122_3344});
    m_addr++; m_cnt++;
    send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    idle(3);
    wait_drain();
    n_checks++;
    if (cnt !== m_cnt || sb.size() != 0 || err !== 1'b0)
      $display("FAIL bp_skid got cnt=%0d left=%0d err=%b want cnt=%0d left=0 err=0",
               cnt, sb.size(), err, m_cnt);
    else n_pass++;
  endtask

  task automatic test_overrun();
    en = 1'b1; gnt = 1'b0;
    do_reset();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    n_checks++;
    if (err !== 1'b1 || core_rst_n !== 1'b0 || done !== 1'b0 || req !== 1'b0)
      $display("FAIL overrun got err=%b crst=%b done=%b req=%b want 1 0 0 0",
               err, core_rst_n, done, req);
    else n_pass++;
    gnt = 1'b1;
    send_word(32'h0BAD_0BAD, 1'b0);
    n_checks++;
    if (n_req !== 0 || err !== 1'b1 || cnt !== '0)
      $display("FAIL overrun_sticky got nreq=%0d err=%b cnt=%0d want 0 1 0",
               n_req, err, cnt);
    else n_pass++;
  endtask

  task automatic test_enable();
    en = 1'b0; gnt = 1'b1;
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    n_checks++;
    if (n_req !== 0 || cnt !== '0 || req !== 1'b0)
      $display("FAIL en_gate got nreq=%0d cnt=%0d req=%b want 0 0 0",
               n_req, cnt, req);
    else n_pass++;
    en = 1'b1;
    idle(2);
    en = 1'b0;
    send_word(32'h5566_7788, 1'b1);
    wait_drain();
    n_checks++;
    if (cnt !== m_cnt || addr !== m_addr || sb.size() != 0)
      $display("FAIL en_load got cnt=%0d addr=%0h want cnt=%0d addr=%0h",
               cnt, addr, m_cnt, m_addr);
    else n_pass++;
  endtask

  task automatic test_capacity();
    en = 1'b1; gnt = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) send_word(rnd_word(), 1'b1);
    send_word(32'hA5A5_A5A5, 1'b0);
    wait_drain();
    n_checks++;
    if (err !== 1'b1 || done !== 1'b0 || n_req !== 4 || cnt !== m_cnt)
      $display("FAIL cap_err got err=%b done=%b nreq=%0d cnt=%0d want 1 0 4 %0d",
               err, done, n_req, cnt, m_cnt);
    else n_pass++;
    do_reset();
    for (int i = 0; i < 4; i++) send_word(rnd_word(), 1'b1);
    send_word(TERM, 1'b0);
    wait_drain();
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || cnt !== 3'd4 || addr !== m_addr || n_req !== 4)
      $display("FAIL cap_term got done=%b err=%b cnt=%0d addr=%0h nreq=%0d want 1 0 4 %0h 4",
               done, err, cnt, addr, m_addr, n_req);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    en = 1'b1; gnt = 1'b0;
    do_reset();
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req !== 1'b0 || wdata !== '0)
      $display("FAIL async_drop got req=%b data=%h want 0 0", req, wdata);
    else n_pass++;
    gnt = 1'b1;
    do_reset();
    send_byte(8'h01); send_byte(8'h02);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req, done, err, core_rst_n, cnt, addr, wdata} !== '0)
      $display("FAIL mid_reset got req=%b done=%b err=%b cnt=%0d want all 0",
               req, done, err, cnt);
    else n_pass++;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    send_word(32'hDDCC_BBAA, 1'b1);
    wait_drain();
    n_checks++;
    if (cnt !== m_cnt || n_req !== 1 || sb.size() != 0)
      $display("FAIL mid_reload got cnt=%0d nreq=%0d want %0d 1", cnt, n_req, m_cnt);
    else n_pass++;
  endtask

  task automatic test_empty();
    en = 1'b1; gnt = 1'b1;
    do_reset();
    send_word(TERM, 1'b0);
    n_checks++;
    if (done !== 1'b1 || core_rst_n !== 1'b1 || err !== 1'b0 ||
        cnt !== '0 || n_req !== 0)
      $display("FAIL empty got done=%b crst=%b err=%b cnt=%0d nreq=%0d want 1 1 0 0 0",
               done, core_rst_n, err, cnt, n_req);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_req    = 0;
    m_addr   = '0;
    m_cnt    = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_enable();
    test_capacity();
    test_mid_reset();
    test_empty();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
